// File: rtl/polar_pkt_sequencer.sv
// ----------------------------------------------------------------------------
// polar_pkt_sequencer
//
// Runs up to num_pack packets through the polar decoder. For each packet it
// asks the loader for the next LLR packet, enables the decoder until it
// reports completion, then sweeps the decoded-result memory against the
// golden memory. It keeps saturating pass/error word counts and guards every
// decode with a watchdog.
//
// Optional feature (macro SEQ_LAT_EN): adds lat_last/lat_max, the decode
// latency of the latest packet and the running maximum since the last start.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   start, num_pack         start pulse and packet count (sampled on start)
//   load_req, load_ack      loader handshake; pack_num valid with load_ack
//   pack_num                decoded-word count of the loaded packet
//   module_en, proc_done    decoder handshake
//   cmp_addr                shared read address of decoded/golden memories
//   dec_rdata, gold_rdata   memory read data, one cycle after cmp_addr
//   mism_valid/pkt/idx      one-cycle mismatch report
//   pass_cnt, err_cnt       saturating matching/mismatching word counts
//   busy, all_done, timeout status (LOAD/RUN/CMP/GAP, DONE, TOUT)
//   lat_last, lat_max       decode latency (SEQ_LAT_EN only)
//
// Handshakes: load_req is a level held for the whole LOAD state and the
// transfer happens in the cycle load_ack is sampled high; module_en is a
// level held for the whole RUN state and the decode ends in the cycle
// proc_done is sampled high. Both requests drop the cycle after completion
// and immediately on reset.
// ----------------------------------------------------------------------------
module polar_pkt_sequencer #(
    parameter int DEC_WIDTH = 140,
    parameter int DEC_ADDRW = 6,
    parameter int PKT_W     = 6,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PKT_W-1:0]     num_pack,
    output logic                 load_req,
    input  logic                 load_ack,
    input  logic [5:0]           pack_num,
    output logic                 module_en,
    input  logic                 proc_done,
    output logic [DEC_ADDRW-1:0] cmp_addr,
    input  logic [DEC_WIDTH-1:0] dec_rdata,
    input  logic [DEC_WIDTH-1:0] gold_rdata,
    output logic                 mism_valid,
    output logic [PKT_W-1:0]     mism_pkt,
    output logic [DEC_ADDRW-1:0] mism_idx,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 busy,
    output logic                 all_done,
    output logic                 timeout
`ifdef SEQ_LAT_EN
    ,
    output logic [CNT_W-1:0]     lat_last,
    output logic [CNT_W-1:0]     lat_max
`endif
);

    localparam int               WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_CMP  = 3'd3,
        S_GAP  = 3'd4,
        S_DONE = 3'd5,
        S_TOUT = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [PKT_W-1:0]     r_num_pack;
    logic [PKT_W-1:0]     r_pkt_idx;
    logic [5:0]           r_pack_num;
    logic [WD_W-1:0]      r_wd;
    logic [5:0]           r_iss_cnt;
    logic [DEC_ADDRW-1:0] r_cmp_addr;
    logic                 r_rd_vld;
    logic [DEC_ADDRW-1:0] r_rd_idx;
    logic                 r_mism_valid;
    logic [PKT_W-1:0]     r_mism_pkt;
    logic [DEC_ADDRW-1:0] r_mism_idx;
    logic [CNT_W-1:0]     r_pass_cnt;
    logic [CNT_W-1:0]     r_err_cnt;

    logic                 w_start_ok;
    logic                 w_wd_expired;
    logic                 w_iss_more;
    logic                 w_more_pkts;

    assign w_start_ok   = start && (r_state inside {S_IDLE, S_DONE, S_TOUT});
    assign w_wd_expired = (r_wd == WD_W'(TIMEOUT - 1));
    // Addresses still to be issued for the current packet.
    assign w_iss_more   = (r_iss_cnt < r_pack_num);
    // Evaluated in GAP, before the packet index advances.
    assign w_more_pkts  = ((r_pkt_idx + PKT_W'(1)) < r_num_pack);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_TOUT: begin
                if (start) begin
                    w_next = (num_pack == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_ack) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                // A completion in the watchdog's last cycle still counts.
                if (proc_done) begin
                    w_next = S_CMP;
                end else if (w_wd_expired) begin
                    w_next = S_TOUT;
                end
            end
            S_CMP: begin
                // Once every address is issued, the last read is being
                // compared in this cycle, so the sweep is complete.
                if (!w_iss_more) begin
                    w_next = S_GAP;
                end
            end
            S_GAP: begin
                w_next = w_more_pkts ? S_LOAD : S_DONE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (pure functions of state so reset clears them at once)
    // ------------------------------------------------------------------
    always_comb begin
        load_req  = (r_state == S_LOAD);
        module_en = (r_state == S_RUN);
        busy      = (r_state inside {S_LOAD, S_RUN, S_CMP, S_GAP});
        all_done  = (r_state == S_DONE);
        timeout   = (r_state == S_TOUT);
    end

    // ------------------------------------------------------------------
    // Packet bookkeeping, watchdog and compare sweep
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_pack   <= '0;
            r_pkt_idx    <= '0;
            r_pack_num   <= '0;
            r_wd         <= '0;
            r_iss_cnt    <= '0;
            r_cmp_addr   <= '0;
            r_rd_vld     <= 1'b0;
            r_rd_idx     <= '0;
            r_mism_valid <= 1'b0;
            r_mism_pkt   <= '0;
            r_mism_idx   <= '0;
            r_pass_cnt   <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_rd_vld     <= 1'b0;
            r_mism_valid <= 1'b0;

            if (w_start_ok) begin
                r_num_pack <= num_pack;
                r_pkt_idx  <= '0;
                r_pass_cnt <= '0;
                r_err_cnt  <= '0;
            end

            if ((r_state == S_LOAD) && load_ack) begin
                r_pack_num <= pack_num;
                r_wd       <= '0;
            end

            if (r_state == S_RUN) begin
                if (proc_done) begin
                    r_iss_cnt  <= '0;
                    r_cmp_addr <= '0;
                end else begin
                    r_wd <= r_wd + WD_W'(1);
                end
            end

            if (r_state == S_CMP) begin
                // Issue stage: present one address per cycle; the address
                // stays on its final value once the sweep is issued.
                if (w_iss_more) begin
                    r_rd_vld  <= 1'b1;
                    r_rd_idx  <= r_cmp_addr;
                    r_iss_cnt <= r_iss_cnt + 6'd1;
                    if ((r_iss_cnt + 6'd1) < r_pack_num) begin
                        r_cmp_addr <= r_cmp_addr + DEC_ADDRW'(1);
                    end
                end
                // Compare stage: read data for r_rd_idx is on the bus now.
                if (r_rd_vld) begin
                    if (dec_rdata == gold_rdata) begin
                        if (r_pass_cnt != CNT_SAT) begin
                            r_pass_cnt <= r_pass_cnt + CNT_W'(1);
                        end
                    end else begin
                        if (r_err_cnt != CNT_SAT) begin
                            r_err_cnt <= r_err_cnt + CNT_W'(1);
                        end
                        r_mism_valid <= 1'b1;
                        r_mism_pkt   <= r_pkt_idx;
                        r_mism_idx   <= r_rd_idx;
                    end
                end
            end

            if (r_state == S_GAP) begin
                r_pkt_idx <= r_pkt_idx + PKT_W'(1);
            end
        end
    end

    assign cmp_addr   = r_cmp_addr;
    assign mism_valid = r_mism_valid;
    assign mism_pkt   = r_mism_pkt;
    assign mism_idx   = r_mism_idx;
    assign pass_cnt   = r_pass_cnt;
    assign err_cnt    = r_err_cnt;

`ifdef SEQ_LAT_EN
    // ------------------------------------------------------------------
    // Decode latency: module_en cycles of the packet, i.e. wd+1 at the
    // proc_done cycle, clipped to the counter range.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_lat_last;
    logic [CNT_W-1:0] r_lat_max;
    logic [31:0]      w_wd_p1;
    logic [CNT_W-1:0] w_lat_now;

    assign w_wd_p1   = 32'(r_wd) + 32'd1;
    assign w_lat_now = (w_wd_p1 > 32'(CNT_SAT)) ? CNT_SAT : w_wd_p1[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_last <= '0;
            r_lat_max  <= '0;
        end else if (w_start_ok) begin
            r_lat_last <= '0;
            r_lat_max  <= '0;
        end else if ((r_state == S_RUN) && proc_done) begin
            r_lat_last <= w_lat_now;
            if (w_lat_now > r_lat_max) begin
                r_lat_max <= w_lat_now;
            end
        end
    end

    assign lat_last = r_lat_last;
    assign lat_max  = r_lat_max;
`endif

endmodule
